// File: rtl/fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_wr_arbiter
// Shares the single write port of the 16-deep async FIFO between NREQ
// requesters in the iWCLK domain. A round-robin arbiter picks one owner. That
// owner then keeps the port until it flags last, reaches MAXBURST beats, or
// drops its request. Writes are held off while the FIFO reports full.
//
// Ports
//   iWCLK   write-domain clock
//   iWRST   asynchronous active-high reset
//   iREQ    per-requester valid
//   iLAST   per-requester last-of-burst qualifier (valid with iREQ)
//   iDAT    requester k word on bits [k*DATAWIDTH +: DATAWIDTH]
//   oGNT    per-requester ready; transfer = iREQ[k] & oGNT[k]
//   iFULL   FIFO full flag (registered, iWCLK domain)
//   oWDAT   FIFO write data (don't-care while oWINC=0)
//   oWINC   FIFO write increment, one word per high cycle
//   oBUSY   high while a burst is granted
//   oOWNER  index of the current or most recent owner
// -----------------------------------------------------------------------------
module fifo_wr_arbiter #(
  parameter int DATAWIDTH = 8,
  parameter int NREQ      = 4,
  parameter int IDXW      = 2,
  parameter int MAXBURST  = 4
) (
  input  logic                      iWCLK,
  input  logic                      iWRST,
  input  logic [NREQ-1:0]           iREQ,
  input  logic [NREQ-1:0]           iLAST,
  input  logic [NREQ*DATAWIDTH-1:0] iDAT,
  output logic [NREQ-1:0]           oGNT,
  input  logic                      iFULL,
  output logic [DATAWIDTH-1:0]      oWDAT,
  output logic                      oWINC,
  output logic                      oBUSY,
  output logic [IDXW-1:0]           oOWNER
);

  localparam int CNTW = 4;

  typedef enum logic {ST_IDLE, ST_BURST} state_t;

  state_t          state_q, state_d;
  logic [IDXW-1:0] owner_q, owner_d;
  logic [IDXW-1:0] ptr_q,   ptr_d;
  logic [CNTW-1:0] cnt_q,   cnt_d;

  logic            busy;
  logic            own_req;
  logic            xfer;
  logic [IDXW-1:0] pick;
  logic            pick_vld;
  logic [IDXW-1:0] idx;

  assign busy    = (state_q == ST_BURST);
  assign own_req = iREQ[owner_q];
  // The FIFO full flag lags a write by one cycle. The FIFO gates that edge
  // internally, so only the registered flag is used here.
  assign xfer    = busy & own_req & ~iFULL;

  // Round-robin search starting at ptr+1. The loop runs from the farthest
  // offset down to the nearest one, so the nearest requester is written last
  // and wins. Offset NREQ truncates to ptr itself, which makes ptr the
  // lowest-priority candidate.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    idx      = '0;
    for (int i = NREQ; i >= 1; i--) begin
      idx = ptr_q + IDXW'(i);
      if (iREQ[idx]) begin
        pick     = idx;
        pick_vld = 1'b1;
      end
    end
  end

  always_comb begin
    oGNT = '0;
    if (busy) oGNT[owner_q] = ~iFULL;
  end

  assign oWINC  = xfer;
  assign oWDAT  = iDAT[owner_q*DATAWIDTH +: DATAWIDTH];
  assign oBUSY  = busy;
  assign oOWNER = owner_q;

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_vld) begin
          owner_d = pick;
          cnt_d   = '0;
          state_d = ST_BURST;
        end
      end
      ST_BURST: begin
        if (!own_req) begin
          // Abandon: no transfer this cycle; the owner drops to lowest priority.
          state_d = ST_IDLE;
          ptr_d   = owner_q;
        end else if (xfer) begin
          cnt_d = cnt_q + CNTW'(1);
          // Last and MAXBURST on the same beat produce a single exit.
          if (iLAST[owner_q] || (cnt_d == CNTW'(MAXBURST))) begin
            state_d = ST_IDLE;
            ptr_d   = owner_q;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge iWCLK or posedge iWRST) begin
    if (iWRST) begin
      state_q <= ST_IDLE;
      owner_q <= '0;
      ptr_q   <= IDXW'(NREQ - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fifo_wr_arbiter
// Directed bench for fifo_wr_arbiter (NREQ=4, DATAWIDTH=8, MAXBURST=4).
// Each cycle is driven just after the rising edge. Outputs are sampled 1 time
// unit later, against hand-derived expected values.
// -----------------------------------------------------------------------------
module tb_fifo_wr_arbiter;

  logic        iWCLK = 1'b0;
  logic        iWRST;
  logic [3:0]  iREQ;
  logic [3:0]  iLAST;
  logic [31:0] iDAT;
  logic [3:0]  oGNT;
  logic        iFULL;
  logic [7:0]  oWDAT;
  logic        oWINC;
  logic        oBUSY;
  logic [1:0]  oOWNER;

  int errors = 0;
  int checks = 0;

  fifo_wr_arbiter #(
    .DATAWIDTH(8),
    .NREQ     (4),
    .IDXW     (2),
    .MAXBURST (4)
  ) dut (
    .iWCLK (iWCLK),
    .iWRST (iWRST),
    .iREQ  (iREQ),
    .iLAST (iLAST),
    .iDAT  (iDAT),
    .oGNT  (oGNT),
    .iFULL (iFULL),
    .oWDAT (oWDAT),
    .oWINC (oWINC),
    .oBUSY (oBUSY),
    .oOWNER(oOWNER)
  );

  always #5 iWCLK = ~iWCLK;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic nxt();
    @(posedge iWCLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Waits 1 time unit so that combinational outputs settle after the inputs
  // change, then compares every output. oWDAT is compared only when a write
  // is expected.
  task automatic look(input string tag, input logic busy, input logic [1:0] own,
                      input logic [3:0] gnt, input logic winc, input logic [7:0] wdat);
    #1;
    chk({tag, ".busy"},  {31'd0, oBUSY},  {31'd0, busy});
    chk({tag, ".owner"}, {30'd0, oOWNER}, {30'd0, own});
    chk({tag, ".gnt"},   {28'd0, oGNT},   {28'd0, gnt});
    chk({tag, ".winc"},  {31'd0, oWINC},  {31'd0, winc});
    if (winc) chk({tag, ".wdat"}, {24'd0, oWDAT}, {24'd0, wdat});
  endtask

  task automatic set_dat(input int k, input logic [7:0] v);
    iDAT[k*8 +: 8] = v;
  endtask

  initial begin
    iWRST = 1'b1;
    iREQ  = '0;
    iLAST = '0;
    iFULL = 1'b0;
    iDAT  = 32'hA3A2A1A0;
    repeat (2) nxt();
    look("rst", 0, 0, 4'b0000, 0, 8'h00);
    iWRST = 1'b0;

    // Test 1: three-word burst from requester 0, ending on last.
    nxt();
    iREQ = 4'b0001;
    set_dat(0, 8'h11);
    look("t1.arb", 0, 0, 4'b0000, 0, 8'h00);
    nxt();
    look("t1.b0", 1, 0, 4'b0001, 1, 8'h11);
    nxt();
    set_dat(0, 8'h22);
    look("t1.b1", 1, 0, 4'b0001, 1, 8'h22);
    nxt();
    set_dat(0, 8'h33);
    iLAST = 4'b0001;
    look("t1.b2", 1, 0, 4'b0001, 1, 8'h33);
    nxt();
    // Pointer is now 0, so requester 1 beats requester 0.
    iLAST = '0;
    iREQ  = 4'b0011;
    set_dat(0, 8'hA0);
    look("t1.idle", 0, 0, 4'b0000, 0, 8'h00);
    nxt();
    look("t1.ptr", 1, 1, 4'b0010, 1, 8'hA1);
    iREQ  = '0;
    iWRST = 1'b1;
    nxt();

    // Test 2: all requesters hold requests; the grant rotates 0,1,2,3,0.
    iWRST = 1'b0;
    iREQ  = 4'b1111;
    look("t2.arb", 0, 0, 4'b0000, 0, 8'h00);
    for (int b = 0; b < 5; b++) begin
      logic [1:0] o;
      o = 2'(b % 4);
      for (int beat = 0; beat < 4; beat++) begin
        nxt();
        look($sformatf("t2.o%0d.b%0d", b, beat), 1, o, 4'(1 << o), 1, 8'hA0 + 8'(o));
      end
      nxt();
      if (b == 4) iREQ = 4'b0010;
      look($sformatf("t2.gap%0d", b), 0, o, 4'b0000, 0, 8'h00);
    end

    // Test 3: owner 1 stalls on full after 2 beats, then finishes 2 more.
    nxt();
    look("t3.b0", 1, 1, 4'b0010, 1, 8'hA1);
    nxt();
    look("t3.b1", 1, 1, 4'b0010, 1, 8'hA1);
    for (int k = 0; k < 5; k++) begin
      nxt();
      iFULL = 1'b1;
      look($sformatf("t3.full%0d", k), 1, 1, 4'b0000, 0, 8'h00);
    end
    nxt();
    iFULL = 1'b0;
    look("t3.b2", 1, 1, 4'b0010, 1, 8'hA1);
    nxt();
    look("t3.b3", 1, 1, 4'b0010, 1, 8'hA1);
    nxt();
    iREQ = 4'b0100;
    look("t3.idle", 0, 1, 4'b0000, 0, 8'h00);

    // Test 4: owner 2 abandons after one beat; requester 3 takes over.
    nxt();
    look("t4.b0", 1, 2, 4'b0100, 1, 8'hA2);
    nxt();
    iREQ = 4'b1000;
    look("t4.drop", 1, 2, 4'b0100, 0, 8'h00);
    nxt();
    look("t4.idle", 0, 2, 4'b0000, 0, 8'h00);
    nxt();
    look("t4.own3", 1, 3, 4'b1000, 1, 8'hA3);

    // Test 5: reset in the middle of owner 3's burst.
    nxt();
    look("t5.b1", 1, 3, 4'b1000, 1, 8'hA3);
    #2;
    iWRST = 1'b1;
    look("t5.rst", 0, 0, 4'b0000, 0, 8'h00);
    iREQ  = 4'b0101;
    iLAST = 4'b0101;
    nxt();
    nxt();
    iWRST = 1'b0;
    look("t5.arb", 0, 0, 4'b0000, 0, 8'h00);
    nxt();
    look("t5.own0", 1, 0, 4'b0001, 1, 8'hA0);
    nxt();
    look("t5.gap", 0, 0, 4'b0000, 0, 8'h00);
    nxt();
    look("t5.own2", 1, 2, 4'b0100, 1, 8'hA2);

    // Test 6: single-beat burst from requester 1.
    nxt();
    iREQ  = 4'b0010;
    iLAST = 4'b0010;
    look("t6.arb", 0, 2, 4'b0000, 0, 8'h00);
    nxt();
    look("t6.b0", 1, 1, 4'b0010, 1, 8'hA1);
    nxt();
    iREQ  = '0;
    iLAST = '0;
    look("t6.idle", 0, 1, 4'b0000, 0, 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
